// File: rtl/nibble_serial_comparator_if.sv
// Operand/result handshake bundle for the nibble-serial magnitude comparator.
// slave is the comparator side, master is the operand source / result consumer.
interface nibble_serial_comparator_if #(
  parameter int WIDTH = 32
);
  localparam int NIB  = WIDTH / 4;
  localparam int CNTW = $clog2(NIB) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic             is_signed;
  logic             out_valid;
  logic             out_ready;
  logic             lt;
  logic             gt;
  logic             eq;
  logic [CNTW-1:0]  nib_count;

  modport slave (
    input  in_valid, X, Y, is_signed, out_ready,
    output in_ready, out_valid, lt, gt, eq, nib_count
  );

  modport master (
    output in_valid, X, Y, is_signed, out_ready,
    input  in_ready, out_valid, lt, gt, eq, nib_count
  );
endinterface

// File: rtl/nibble_serial_comparator.sv
// Multi-cycle magnitude comparator: walks the operands one nibble per cycle,
// MSB first, and stops at the first nibble that differs.
module nibble_serial_comparator #(
  parameter int WIDTH = 32
) (
  input logic                      clk,
  input logic                      rst_n,
  nibble_serial_comparator_if.slave bus
);
  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int CNTW = $clog2(NIB) + 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

  stateT            state;
  stateT            stateNext;
  logic [WIDTH-1:0] xReg;
  logic [WIDTH-1:0] yReg;
  logic             signedReg;
  logic [IDXW-1:0]  idx;
  logic [CNTW-1:0]  count;
  logic             ltReg;
  logic             gtReg;
  logic             eqReg;

  logic [3:0]       xNib;
  logic [3:0]       yNib;
  logic             decide;
  logic             decLt;
  logic             decGt;
  logic             decEq;

  // Only the top nibble can see a sign mismatch; once signs agree, unsigned ordering holds.
  always_comb begin
    stateNext = state;
    decide    = 1'b0;
    decLt     = 1'b0;
    decGt     = 1'b0;
    decEq     = 1'b0;
    xNib      = xReg[{idx, 2'b00} +: 4];
    yNib      = yReg[{idx, 2'b00} +: 4];
    case (state)
      IDLE: begin
        if (bus.in_valid) stateNext = RUN;
      end
      RUN: begin
        if (signedReg && (idx == LAST_IDX) && (xReg[WIDTH-1] != yReg[WIDTH-1])) begin
          decide = 1'b1;
          decLt  = xReg[WIDTH-1];
          decGt  = ~xReg[WIDTH-1];
        end else if (xNib != yNib) begin
          decide = 1'b1;
          decLt  = (xNib < yNib);
          decGt  = (xNib > yNib);
        end else if (idx == '0) begin
          decide = 1'b1;
          decEq  = 1'b1;
        end
        if (decide) stateNext = DONE;
      end
      DONE: begin
        if (bus.out_ready) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      xReg      <= '0;
      yReg      <= '0;
      signedReg <= 1'b0;
      idx       <= '0;
      count     <= '0;
      ltReg     <= 1'b0;
      gtReg     <= 1'b0;
      eqReg     <= 1'b0;
    end else begin
      state <= stateNext;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            xReg      <= bus.X;
            yReg      <= bus.Y;
            signedReg <= bus.is_signed;
            idx       <= LAST_IDX;
            count     <= '0;
          end
        end
        RUN: begin
          count <= count + 1'b1;
          if (decide) begin
            ltReg <= decLt;
            gtReg <= decGt;
            eqReg <= decEq;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.lt        = ltReg;
  assign bus.gt        = gtReg;
  assign bus.eq        = eqReg;
  assign bus.nib_count = count;
endmodule

// File: tb/tb_nibble_serial_comparator.sv
// Scoreboard bench for nibble_serial_comparator: expected results are queued
// at operand acceptance and compared when out_valid appears.
module tb_nibble_serial_comparator;
  localparam int WIDTH = 32;
  localparam int NIB   = WIDTH / 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   testCount = 0;
  int   failCount = 0;
  int   cycle = 0;

  typedef struct {
    logic lt;
    logic gt;
    logic eq;
    int   nibs;
  } expT;

  expT expQ[$];

  nibble_serial_comparator_if #(.WIDTH(WIDTH)) bus ();

  nibble_serial_comparator #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Reference: full-width relational compare plus position of the first differing nibble.
  function automatic expT model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s);
    expT e;
    logic found;
    e.lt = s ? ($signed(x) < $signed(y)) : (x < y);
    e.gt = s ? ($signed(x) > $signed(y)) : (x > y);
    e.eq = (x == y);
    e.nibs = NIB;
    found = 1'b0;
    if (s && (x[WIDTH-1] != y[WIDTH-1])) begin
      e.nibs = 1;
      found = 1'b1;
    end
    for (int i = NIB - 1; i >= 0; i--) begin
      if (!found && (x[i*4 +: 4] != y[i*4 +: 4])) begin
        e.nibs = NIB - i;
        found = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic applyStimulus(input string name, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                               input logic s, input int holdCycles);
    expT e;
    int  acceptCycle;
    int  waitN;
    bit  seen;
    @(negedge clk);
    bus.X         = x;
    bus.Y         = y;
    bus.is_signed = s;
    bus.in_valid  = 1'b1;
    waitN = 0;
    while (!bus.in_ready && waitN < 20) begin
      @(negedge clk);
      waitN++;
    end
    if (!bus.in_ready) begin
      checkOutput({name, " accept timeout"}, 32'd0, 32'd1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    acceptCycle   = cycle;
    bus.in_valid  = 1'b0;
    bus.X         = $urandom;
    bus.Y         = $urandom;
    bus.is_signed = ~s;
    expQ.push_back(model(x, y, s));

    seen = 1'b0;
    for (int i = 0; i < 2 * NIB + 4 && !seen; i++) begin
      if (bus.out_valid) seen = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    e = expQ.pop_front();
    if (!seen) begin
      checkOutput({name, " out_valid timeout"}, 32'd0, 32'd1);
      return;
    end
    checkOutput({name, " latency"}, 32'(cycle - acceptCycle), 32'(e.nibs));
    checkOutput({name, " lt"}, 32'(bus.lt), 32'(e.lt));
    checkOutput({name, " gt"}, 32'(bus.gt), 32'(e.gt));
    checkOutput({name, " eq"}, 32'(bus.eq), 32'(e.eq));
    checkOutput({name, " nib_count"}, 32'(bus.nib_count), 32'(e.nibs));

    for (int h = 0; h < holdCycles; h++) begin
      @(posedge clk);
      #1;
      checkOutput({name, " hold out_valid"}, 32'(bus.out_valid), 32'd1);
      checkOutput({name, " hold in_ready"}, 32'(bus.in_ready), 32'd0);
      checkOutput({name, " hold flags"}, {29'd0, bus.lt, bus.gt, bus.eq}, {29'd0, e.lt, e.gt, e.eq});
      checkOutput({name, " hold nib_count"}, 32'(bus.nib_count), 32'(e.nibs));
    end

    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    checkOutput({name, " post out_valid"}, 32'(bus.out_valid), 32'd0);
    checkOutput({name, " post in_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    logic [WIDTH-1:0] rx;
    logic [WIDTH-1:0] ry;
    logic             rs;
    bit               sawValid;

    bus.in_valid  = 1'b0;
    bus.X         = '0;
    bus.Y         = '0;
    bus.is_signed = 1'b0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("reset out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset flags", {29'd0, bus.lt, bus.gt, bus.eq}, 32'd0);
    checkOutput("reset nib_count", 32'(bus.nib_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus("unsigned equal", 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 0);
    applyStimulus("msb early exit", 32'h10000000, 32'h0FFFFFFF, 1'b0, 0);
    applyStimulus("signed -1 vs 1", 32'hFFFFFFFF, 32'h00000001, 1'b1, 0);
    applyStimulus("unsigned max vs 1", 32'hFFFFFFFF, 32'h00000001, 1'b0, 0);
    applyStimulus("lsb both negative", 32'h80000003, 32'h80000005, 1'b1, 0);
    applyStimulus("backpressure", 32'h12345678, 32'h12335678, 1'b0, 5);
    applyStimulus("back-to-back", 32'h7FFFFFFF, 32'h80000000, 1'b1, 0);

    // Abort an equal-operand compare three edges after acceptance.
    @(negedge clk);
    bus.X        = 32'hCAFEF00D;
    bus.Y        = 32'hCAFEF00D;
    bus.is_signed = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midrun reset in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("midrun reset out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("midrun reset flags", {29'd0, bus.lt, bus.gt, bus.eq}, 32'd0);
    checkOutput("midrun reset nib_count", 32'(bus.nib_count), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sawValid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) sawValid = 1'b1;
    end
    checkOutput("no out_valid after reset", 32'(sawValid), 32'd0);
    applyStimulus("after reset", 32'h00000042, 32'h00000041, 1'b1, 0);

    for (int t = 0; t < 8; t++) begin
      rx = $urandom;
      ry = rx ^ (WIDTH'($urandom_range(0, 15)) << (4 * $urandom_range(0, NIB - 1)));
      rs = 1'($urandom_range(0, 1));
      applyStimulus($sformatf("random %0d", t), rx, ry, rs, t % 3);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end
endmodule

// File: doc/nibble_serial_comparator.md
Name: nibble_serial_comparator

Overview:
- Multi-cycle magnitude comparator for MIPS datapath operands (slt/sltu, branch-compare paths) that cannot afford a full-width combinational compare.
- Examines operands one 4-bit nibble per cycle, MSB nibble first, and terminates as soon as a nibble differs.
- Valid/ready handshake on both input and result sides.
- Produces mutually exclusive lt/gt/eq flags plus the number of nibbles examined.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of 4 and >= 4. Derived NIB = WIDTH/4.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair presented
- in_ready  output  1  block can accept operands
- X  input  WIDTH  left operand
- Y  input  WIDTH  right operand
- is_signed  input  1  1 = two's-complement compare, 0 = unsigned
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- lt  output  1  X < Y
- gt  output  1  X > Y
- eq  output  1  X == Y
- nib_count  output  clog2(NIB)+1  nibbles examined for this result (1..NIB)

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous and active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, lt=gt=eq=0, nib_count=0, all internal operand/index registers 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On the edge where in_valid&in_ready: register X, Y and is_signed; set idx=NIB-1; go to RUN.
  - X, Y and is_signed are don't-care at all other times.
- RUN:
  - in_ready=0.
  - Each cycle, compare nibble idx of the registered X and Y; increment the internal count.
  - Signed mode, idx==NIB-1 only: if X[WIDTH-1]!=Y[WIDTH-1], decide immediately. lt=X[WIDTH-1], gt=~X[WIDTH-1]. Otherwise compare the nibble unsigned (equal signs make unsigned ordering correct).
  - Nibbles differ: lt = (Xn<Yn), gt = (Xn>Yn), eq=0; go to DONE.
  - Nibbles equal and idx==0: eq=1, lt=gt=0; go to DONE.
  - Otherwise: idx decrements by 1; stay in RUN.
- DONE:
  - out_valid=1. lt, gt, eq and nib_count are held stable until the handshake.
  - On out_valid&out_ready: return to IDLE, deassert out_valid. Flags keep their values; they are meaningful only while out_valid=1.
  - in_ready=0 in DONE. A new operand pair cannot be accepted on the same edge as the result handshake; earliest accept is the following cycle.
- Latency:
  - Operands accepted at edge k; out_valid rises at edge k+m, where m = nibbles examined (1..NIB).
  - Worst case, equal operands: m=NIB (8 for WIDTH=32).
- Invariant: exactly one of lt/gt/eq is 1 whenever out_valid=1.
- Back-pressure: out_ready low holds DONE indefinitely, with outputs stable.
- Input-side changes: changes on X, Y or is_signed after acceptance have no effect on the result.
- Reset mid-operation: an asynchronous rst_n assertion in RUN or DONE immediately returns the block to reset values; the in-flight result is discarded with no out_valid pulse.
- in_valid during RUN/DONE: ignored (in_ready=0); the source holds its data per the handshake.

Test Plan:
- Unsigned equal: X=Y=32'hDEADBEEF, is_signed=0 -> out_valid at accept+8, eq=1, lt=gt=0, nib_count=8.
- Early exit on MSB nibble: X=32'h10000000, Y=32'h0FFFFFFF, unsigned -> out_valid at accept+1, gt=1, nib_count=1.
- Signed vs unsigned on the same operands:
  - X=32'hFFFFFFFF, Y=32'h00000001, is_signed=1 -> lt=1, nib_count=1.
  - Same operands, is_signed=0 -> gt=1, nib_count=1.
- Differ only in LSB nibble, both negative: X=32'h80000003, Y=32'h80000005, signed -> lt=1, nib_count=8.
- Back-pressure:
  - Hold out_ready=0 for 5 cycles after out_valid -> flags and nib_count stable, in_ready=0 throughout.
  - Raise out_ready -> IDLE next cycle, in_ready=1.
  - Inject a second pair immediately -> correct second result.
- Reset mid-RUN: assert rst_n=0 at accept+3 of an equal-operand compare -> in_ready=1 and out_valid=0 asynchronously; no out_valid afterwards. A fresh compare after release yields the correct result.
